// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC-driven req/ack instruction fetch into IR with misalignment check.
// Optional memory-ack timeout enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_unit #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              fetchStart,
   input  logic [ADDR_W-1:0] pcIn,
   input  logic              clearErr,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memRdata,
   output logic [DATA_W-1:0] IR,
   output logic              fetchDone,
   output logic              busy,
   output logic              misaligned,
   output logic              timeout
);
   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] ir_nx;
   logic mis_nx;
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end
`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt, cnt_nx;
   logic to_nx;
   logic expired;
   assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   assign memReq    = state == REQ;
   assign fetchDone = state == DONE;
   assign busy      = state != IDLE;
   always_comb begin
      state_nx = state;
      addr_nx  = memAddr;
      ir_nx    = IR;
      mis_nx   = misaligned;
`ifdef FETCH_TIMEOUT_EN
      cnt_nx   = cnt;
      to_nx    = timeout;
`endif
      case (state)
         IDLE: if (fetchStart) begin
            if (pcIn[1:0] == 2'b00) begin
               state_nx = REQ;
               addr_nx  = pcIn;
`ifdef FETCH_TIMEOUT_EN
               cnt_nx   = '0;
`endif
            end else begin
               state_nx = ERR;
               mis_nx   = 1'b1;
            end
         end
         REQ: if (memAck) begin
            state_nx = DONE;
            ir_nx    = memRdata;
         end
`ifdef FETCH_TIMEOUT_EN
         else if (expired) begin
            state_nx = ERR;
            to_nx    = 1'b1;
         end else cnt_nx = cnt + 1'b1;
`endif
         DONE: state_nx = IDLE;
         ERR: if (clearErr) begin
            state_nx = IDLE;
            mis_nx   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_nx    = 1'b0;
`endif
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         memAddr    <= '0;
         IR         <= '0;
         misaligned <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt        <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         state      <= state_nx;
         memAddr    <= addr_nx;
         IR         <= ir_nx;
         misaligned <= mis_nx;
`ifdef FETCH_TIMEOUT_EN
         cnt        <= cnt_nx;
         timeout    <= to_nx;
`endif
      end
   end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized self-checking bench against a transaction-level fetch model.
module tb_inst_fetch_unit;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic fetchStart = 1'b0, clearErr = 1'b0, memAck = 1'b0;
   logic [31:0] pcIn = '0, memRdata = '0;
   logic memReq, fetchDone, busy, misaligned, timeout;
   logic [31:0] memAddr, IR;
   int total = 0, bad = 0;
   logic [31:0] exp_ir = '0;

   inst_fetch_unit dut (
      .CLK(CLK), .RST(RST), .fetchStart(fetchStart), .pcIn(pcIn), .clearErr(clearErr),
      .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memRdata(memRdata),
      .IR(IR), .fetchDone(fetchDone), .busy(busy), .misaligned(misaligned), .timeout(timeout)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int delay, input int pulse_at);
      fetchStart = 1'b1; pcIn = pc; memAck = 1'b0;
      step();
      fetchStart = 1'b0; pcIn = $urandom;
      total++;
      if (memReq !== 1'b1 || memAddr !== pc || busy !== 1'b1 || fetchDone !== 1'b0) begin
         bad++;
         $display("FAIL req_start pc=%h memReq=%b memAddr=%h busy=%b fetchDone=%b (want 1,%h,1,0)", pc, memReq, memAddr, busy, fetchDone, pc);
      end
      for (int d = 0; d < delay; d++) begin
         fetchStart = (d == pulse_at); pcIn = {$urandom} & 32'hFFFF_FFFC; memRdata = $urandom;
         step();
         fetchStart = 1'b0;
         total++;
         if (memReq !== 1'b1 || memAddr !== pc || fetchDone !== 1'b0 || IR !== exp_ir) begin
            bad++;
            $display("FAIL req_hold cyc=%0d memReq=%b memAddr=%h fetchDone=%b IR=%h (want 1,%h,0,%h)", d, memReq, memAddr, fetchDone, IR, pc, exp_ir);
         end
      end
      memAck = 1'b1; memRdata = data;
      step();
      memAck = 1'b0; memRdata = $urandom;
      exp_ir = data;
      total++;
      if (fetchDone !== 1'b1 || IR !== data || memReq !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL done fetchDone=%b IR=%h memReq=%b busy=%b timeout=%b (want 1,%h,0,1,0)", fetchDone, IR, memReq, busy, timeout, data);
      end
      fetchStart = (pulse_at >= 0); pcIn = 32'h0000_0040;
      step();
      fetchStart = 1'b0;
      total++;
      if (fetchDone !== 1'b0 || busy !== 1'b0 || memReq !== 1'b0 || IR !== data) begin
         bad++;
         $display("FAIL after_done fetchDone=%b busy=%b memReq=%b IR=%h (want 0,0,0,%h)", fetchDone, busy, memReq, IR, data);
      end
   endtask

   task automatic do_misaligned(input logic [31:0] pc);
      fetchStart = 1'b1; pcIn = pc;
      step();
      fetchStart = 1'b0;
      total++;
      if (misaligned !== 1'b1 || busy !== 1'b1 || memReq !== 1'b0 || IR !== exp_ir) begin
         bad++;
         $display("FAIL mis_enter pc=%h misaligned=%b busy=%b memReq=%b IR=%h (want 1,1,0,%h)", pc, misaligned, busy, memReq, IR, exp_ir);
      end
      for (int i = 0; i < 3; i++) begin
         memAck = $urandom; memRdata = $urandom;
         step();
         total++;
         if (misaligned !== 1'b1 || busy !== 1'b1 || memReq !== 1'b0 || IR !== exp_ir || fetchDone !== 1'b0) begin
            bad++;
            $display("FAIL mis_hold misaligned=%b busy=%b memReq=%b IR=%h fetchDone=%b (want 1,1,0,%h,0)", misaligned, busy, memReq, IR, fetchDone, exp_ir);
         end
      end
      memAck = 1'b0; clearErr = 1'b1;
      step();
      clearErr = 1'b0;
      total++;
      if (misaligned !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || IR !== exp_ir) begin
         bad++;
         $display("FAIL mis_clear misaligned=%b busy=%b timeout=%b IR=%h (want 0,0,0,%h)", misaligned, busy, timeout, IR, exp_ir);
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fetchStart = $urandom; pcIn = $urandom; clearErr = $urandom; memAck = $urandom; memRdata = $urandom;
         step();
         total++;
         if ({memReq, fetchDone, busy, misaligned, timeout} !== 5'b0 || memAddr !== 32'h0 || IR !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold memReq=%b fetchDone=%b busy=%b mis=%b to=%b memAddr=%h IR=%h (want all 0)", memReq, fetchDone, busy, misaligned, timeout, memAddr, IR);
         end
      end
      fetchStart = 1'b0; clearErr = 1'b0; memAck = 1'b0;
      RST = 1'b1;
      step();
      total++;
      if (busy !== 1'b0 || memReq !== 1'b0) begin
         bad++;
         $display("FAIL reset_release busy=%b memReq=%b (want 0,0)", busy, memReq);
      end
      exp_ir = '0;
   endtask

   task automatic test_zero_wait();
      do_fetch(32'h0000_0004, 32'h8C01_0004, 0, -1);
   endtask

   task automatic test_wait_states();
      do_fetch(32'h0000_0100, 32'hDEAD_BEEF, 5, 2);
   endtask

   task automatic test_misaligned();
      do_misaligned(32'h0000_0006);
      do_fetch(32'h0000_000C, 32'h1234_5678, 1, -1);
   endtask

   task automatic test_clear_idle();
      clearErr = 1'b1;
      step();
      clearErr = 1'b0;
      total++;
      if (busy !== 1'b0 || misaligned !== 1'b0 || memReq !== 1'b0 || IR !== exp_ir) begin
         bad++;
         $display("FAIL clear_idle busy=%b mis=%b memReq=%b IR=%h (want 0,0,0,%h)", busy, misaligned, memReq, IR, exp_ir);
      end
   endtask

   task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
      int n = 0;
      fetchStart = 1'b1; pcIn = 32'h0000_0010; memAck = 1'b0;
      step();
      fetchStart = 1'b0;
      for (int i = 0; i < 40 && memReq === 1'b1; i++) begin
         n++;
         step();
      end
      total++;
      if (n != 16 || timeout !== 1'b1 || busy !== 1'b1 || IR !== exp_ir || misaligned !== 1'b0) begin
         bad++;
         $display("FAIL timeout_fire reqcycles=%0d timeout=%b busy=%b IR=%h mis=%b (want 16,1,1,%h,0)", n, timeout, busy, IR, misaligned, exp_ir);
      end
      clearErr = 1'b1;
      step();
      clearErr = 1'b0;
      total++;
      if (timeout !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL timeout_clear timeout=%b busy=%b (want 0,0)", timeout, busy);
      end
      do_fetch(32'h0000_0014, 32'hCAFE_F00D, 15, -1);
`else
      fetchStart = 1'b1; pcIn = 32'h0000_0010; memAck = 1'b0;
      step();
      fetchStart = 1'b0;
      for (int i = 0; i < 100; i++) step();
      total++;
      if (memReq !== 1'b1 || timeout !== 1'b0 || busy !== 1'b1 || memAddr !== 32'h10) begin
         bad++;
         $display("FAIL no_timeout memReq=%b timeout=%b busy=%b memAddr=%h (want 1,0,1,00000010)", memReq, timeout, busy, memAddr);
      end
      memAck = 1'b1; memRdata = 32'hCAFE_F00D;
      step();
      memAck = 1'b0;
      exp_ir = 32'hCAFE_F00D;
      step();
`endif
   endtask

   task automatic test_reset_mid_req();
      fetchStart = 1'b1; pcIn = 32'h0000_0020; memAck = 1'b0;
      step();
      fetchStart = 1'b0;
      step();
      step();
      #2 RST = 1'b0;
      #1;
      exp_ir = '0;
      total++;
      if (memReq !== 1'b0 || IR !== 32'h0 || busy !== 1'b0 || memAddr !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid memReq=%b IR=%h busy=%b memAddr=%h (want 0,0,0,0)", memReq, IR, busy, memAddr);
      end
      @(posedge CLK);
      #1 RST = 1'b1;
      do_fetch(32'h0000_0008, 32'hA5A5_0008, 2, -1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++) begin
         logic [31:0] pc;
         pc = $urandom;
         if ($urandom_range(3) == 0) begin
            if (pc[1:0] == 2'b00) pc[0] = 1'b1;
            do_misaligned(pc);
         end else begin
            pc[1:0] = 2'b00;
            do_fetch(pc, $urandom, int'($urandom_range(7)), $urandom_range(1) ? int'($urandom_range(7)) : -1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_misaligned();
      test_clear_idle();
      test_timeout();
      test_reset_mid_req();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
